// File: rtl/mem_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_pkg                                                              |
// | Shared types for the req/gnt/rvalid data-bus initiator.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_bus_pkg;

  // Full bus command; wdata is sized for the widest bus (32 data + cap tag).
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
  } mem_cmd_t;

  // What a response needs from its originating command.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } pend_ent_t;

  // Bus side state: IDLE drives data_req low, REQ drives it high.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } init_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_init_pend_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_init_pend_fifo                                                       |
// | Synchronous FIFO holding accepted-but-unanswered commands. Pointers     |
// | carry an extra wrap bit so full and empty are distinguishable.          |
// | Push and pop in the same cycle are legal even when full.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_init_pend_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state: write at tail on push, advance head on pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // State registers; reset discards all pending entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_initiator                                                            |
// | Initiator side of the req/gnt/rvalid data bus. Turns valid/ready        |
// | commands into registered bus requests, keeps up to MAX_OUTST commands  |
// | in flight and returns in-order responses one cycle after rvalid.       |
// | Flags rvalid with no granted request outstanding (proto_err).          |
// | Optional grant watchdog: define MEM_INIT_TIMEOUT_EN.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned MEM_DW    = 32,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [3:0]        cmd_be,
  input  logic [31:0]       cmd_addr,
  input  logic [MEM_DW-1:0] cmd_wdata,
  output logic              data_req,
  output logic              data_we,
  output logic [3:0]        data_be,
  output logic [31:0]       data_addr,
  output logic [MEM_DW-1:0] data_wdata,
  input  logic              data_gnt,
  input  logic              data_rvalid,
  input  logic [MEM_DW-1:0] data_rdata,
  input  logic              data_err,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [31:0]       rsp_addr,
  output logic [MEM_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              proto_err,
  output logic              gnt_timeout
);

  localparam int unsigned CNT_W    = $clog2(MAX_OUTST) + 1;
  localparam logic [0:0]  ST_IDLE  = IDLE;
  localparam logic [0:0]  ST_REQ   = REQ;

  logic [0:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       addr_q, addr_d;
  logic [MEM_DW-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  gnt_cnt_q, gnt_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic [31:0]       rsp_addr_q, rsp_addr_d;
  logic [MEM_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              proto_err_q, proto_err_d;

  logic      grant, accept, pop;
  logic      pend_full, pend_empty;
  pend_ent_t push_ent, head_ent;

  assign data_req   = (state_q == ST_REQ);
  assign grant      = data_req && data_gnt;
  // A response is only legal when some granted request is still unanswered.
  assign pop        = data_rvalid && (gnt_cnt_q != '0) && !pend_empty;
  assign cmd_ready  = (!data_req || data_gnt) && (!pend_full || pop);
  assign accept     = cmd_valid && cmd_ready;
  assign push_ent   = '{we: cmd_we, addr: cmd_addr};

  assign data_we    = we_q;
  assign data_be    = be_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_we     = rsp_we_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign proto_err  = proto_err_q;

  mem_init_pend_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH ($bits(pend_ent_t))
  ) u_pend_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_ent),
    .pop       (pop),
    .full      (pend_full),
    .empty     (pend_empty),
    .head      (head_ent)
  );

  // Next-state for bus FSM, bus fields, grant counter, response and flags.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt_cnt_d   = gnt_cnt_q;
    rsp_valid_d = pop;
    rsp_we_d    = rsp_we_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    proto_err_d = proto_err_q | (data_rvalid && (gnt_cnt_q == '0));

    // Bus fields only load on accept, which can only happen when the
    // current request (if any) is being granted, so they never move early.
    if (accept) begin
      state_d = ST_REQ;
      we_d    = cmd_we;
      be_d    = cmd_be;
      addr_d  = cmd_addr;
      wdata_d = cmd_wdata;
    end else if (grant) begin
      state_d = ST_IDLE;
    end

    if (grant && !pop) begin
      gnt_cnt_d = gnt_cnt_q + CNT_W'(1);
    end else if (!grant && pop) begin
      gnt_cnt_d = gnt_cnt_q - CNT_W'(1);
    end

    if (pop) begin
      rsp_we_d    = head_ent.we;
      rsp_addr_d  = head_ent.addr;
      rsp_rdata_d = head_ent.we ? '0 : data_rdata;
      rsp_err_d   = data_err;
    end
  end

  // State registers; async reset drops data_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_cnt_q   <= gnt_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef MEM_INIT_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            gnt_timeout_q, gnt_timeout_d;

  assign gnt_timeout = gnt_timeout_q;

  // Watchdog: count ungranted request cycles, saturate at TIMEOUT.
  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    gnt_timeout_d = gnt_timeout_q;
    if (!data_req || data_gnt) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_W'(TIMEOUT)) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    if (wd_cnt_d == WD_W'(TIMEOUT)) begin
      gnt_timeout_d = 1'b1;
    end
  end

  // Watchdog registers; the flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      gnt_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      gnt_timeout_q <= gnt_timeout_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign gnt_timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_mem_initiator                                                         |
// | Self-checking bench for mem_initiator: directed scenarios followed by   |
// | randomized traffic against a queue-based transaction model.             |
// | Honours MEM_INIT_TIMEOUT_EN for the watchdog expectation.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_initiator;

  localparam int MAX_OUTST = 4;
  localparam int MEM_DW    = 32;
  localparam int TIMEOUT   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic              cmd_we = 1'b0;
  logic [3:0]        cmd_be = '0;
  logic [31:0]       cmd_addr = '0;
  logic [MEM_DW-1:0] cmd_wdata = '0;
  logic              data_req, data_we;
  logic [3:0]        data_be;
  logic [31:0]       data_addr;
  logic [MEM_DW-1:0] data_wdata;
  logic              data_gnt = 1'b0, data_rvalid = 1'b0, data_err = 1'b0;
  logic [MEM_DW-1:0] data_rdata = '0;
  logic              rsp_valid, rsp_we, rsp_err, proto_err, gnt_timeout;
  logic [31:0]       rsp_addr;
  logic [MEM_DW-1:0] rsp_rdata;

  always #5 clk = ~clk;

  mem_initiator #(
    .MAX_OUTST (MAX_OUTST),
    .MEM_DW    (MEM_DW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_we (cmd_we),
    .cmd_be (cmd_be), .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
    .data_req (data_req), .data_we (data_we), .data_be (data_be),
    .data_addr (data_addr), .data_wdata (data_wdata), .data_gnt (data_gnt),
    .data_rvalid (data_rvalid), .data_rdata (data_rdata), .data_err (data_err),
    .rsp_valid (rsp_valid), .rsp_we (rsp_we), .rsp_addr (rsp_addr),
    .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
    .proto_err (proto_err), .gnt_timeout (gnt_timeout)
  );

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Model: commands accepted but not yet granted, and granted but unanswered.
  cmd_t        busq[$];
  cmd_t        memq[$];
  bit          exp_rsp_valid, exp_rsp_we, exp_rsp_err;
  logic [31:0] exp_rsp_addr, exp_rsp_rdata;
  bit          exp_proto, exp_tmo;
  int          wait_cycles;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic cmd_t mk(bit we, logic [3:0] be, logic [31:0] a, logic [31:0] d);
    cmd_t c;
    c.we = we; c.be = be; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(bit'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit v, input cmd_t c, input bit g, input bit rv,
                      input logic [31:0] rd, input bit er, output bit acc);
    bit exp_ready;
    bit legal_rv;
    @(negedge clk);
    cmd_valid = v; cmd_we = c.we; cmd_be = c.be; cmd_addr = c.addr; cmd_wdata = c.wdata;
    data_gnt = g; data_rvalid = rv; data_rdata = rd; data_err = er;
    #1;
    legal_rv  = rv && (memq.size() != 0);
    exp_ready = (busq.size() == 0 || g) &&
                ((busq.size() + memq.size()) < MAX_OUTST || legal_rv);
    check("data_req", data_req, busq.size() != 0);
    if (busq.size() != 0) begin
      check("data_we", data_we, busq[0].we);
      check("data_be", data_be, busq[0].be);
      check("data_addr", data_addr, busq[0].addr);
      check("data_wdata", data_wdata, busq[0].wdata);
    end
    check("cmd_ready", cmd_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_rsp_valid);
    if (exp_rsp_valid) begin
      check("rsp_we", rsp_we, exp_rsp_we);
      check("rsp_addr", rsp_addr, exp_rsp_addr);
      check("rsp_rdata", rsp_rdata, exp_rsp_rdata);
      check("rsp_err", rsp_err, exp_rsp_err);
    end
    check("proto_err", proto_err, exp_proto);
    check("gnt_timeout", gnt_timeout, exp_tmo);
    acc = v && exp_ready;
    @(posedge clk);
    exp_rsp_valid = 1'b0;
    if (rv) begin
      if (memq.size() == 0) begin
        exp_proto = 1'b1;
      end else begin
        cmd_t h;
        h = memq.pop_front();
        exp_rsp_valid = 1'b1;
        exp_rsp_we    = h.we;
        exp_rsp_addr  = h.addr;
        exp_rsp_rdata = h.we ? 32'h0 : rd;
        exp_rsp_err   = er;
      end
    end
`ifdef MEM_INIT_TIMEOUT_EN
    if (busq.size() != 0 && !g) begin
      wait_cycles++;
      if (wait_cycles >= TIMEOUT) exp_tmo = 1'b1;
    end else begin
      wait_cycles = 0;
    end
`endif
    if (busq.size() != 0 && g) memq.push_back(busq.pop_front());
    if (acc) busq.push_back(c);
  endtask

  task automatic idle(input bit g);
    bit a;
    step(1'b0, mk(0, 0, 0, 0), g, 1'b0, 32'h0, 1'b0, a);
  endtask

  // Grant and answer everything still in flight.
  task automatic drain();
    bit a;
    for (int i = 0; i < 40 && (busq.size() != 0 || memq.size() != 0); i++)
      step(1'b0, mk(0, 0, 0, 0), 1'b1, memq.size() != 0, $urandom, 1'b0, a);
    check("drain_done", busq.size() + memq.size(), 0);
    idle(1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic apply_reset();
    @(negedge clk);
    cmd_valid = 0; data_gnt = 0; data_rvalid = 0; data_err = 0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_data_req", data_req, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_gnt_timeout", gnt_timeout, 1'b0);
    busq.delete(); memq.delete();
    exp_rsp_valid = 0; exp_proto = 0; exp_tmo = 0; wait_cycles = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit   a;
    int   sent;
    cmd_t cur;

    // Reset state
    apply_reset();
    #1;
    check("init_cmd_ready", cmd_ready, 1'b1);
    check("init_data_addr", data_addr, 32'h0);
    check("init_rsp_addr", rsp_addr, 32'h0);
    check("init_rsp_rdata", rsp_rdata, 32'h0);

    // Single read, grant in first request cycle, rvalid one cycle later
    step(1'b1, mk(0, 4'hF, 32'h100, 32'h0), 1'b0, 1'b0, 32'h0, 1'b0, a);
    idle(1'b1);
    step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, a);
    idle(1'b0);
    idle(1'b0);

    // Write with grant delayed 3 cycles; read data must be suppressed
    step(1'b1, mk(1, 4'b0011, 32'h204, 32'hCAFE_F00D), 1'b0, 1'b0, 32'h0, 1'b0, a);
    repeat (3) idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b1, 32'h1234_5678, 1'b1, a);
    idle(1'b0);

    // Back-to-back reads with rvalid withheld: stall at MAX_OUTST
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(0, 4'hF, 32'h300 + 32'(4 * sent), 32'h0), 1'b1, 1'b0, 32'h0, 1'b0, a);
      if (a) sent++;
    end
    step(1'b1, mk(0, 4'hF, 32'h300 + 32'(4 * sent), 32'h0), 1'b1, 1'b1, 32'h5555_AAAA, 1'b0, a);
    drain();

    // rvalid with nothing granted: sticky proto_err, cleared by reset
    step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b1, 32'h0, 1'b0, a);
    repeat (2) idle(1'b0);
    apply_reset();
    idle(1'b0);

    // Reset while requesting with two pending; late rvalid afterwards
    step(1'b1, mk(0, 4'hF, 32'h400, 32'h0), 1'b0, 1'b0, 32'h0, 1'b0, a);
    step(1'b1, mk(1, 4'hF, 32'h404, 32'h77), 1'b1, 1'b0, 32'h0, 1'b0, a);
    apply_reset();
    idle(1'b0);
    step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b1, 32'h0, 1'b0, a);
    idle(1'b0);
    apply_reset();

    // Grant withheld past the watchdog limit; request must stay up
    step(1'b1, mk(0, 4'hF, 32'h500, 32'h0), 1'b0, 1'b0, 32'h0, 1'b0, a);
    repeat (TIMEOUT + 2) idle(1'b0);
    drain();
    apply_reset();

    // Randomized traffic
    cur = rnd_cmd();
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 1)), cur, ($urandom_range(0, 3) != 0),
           (memq.size() != 0) && bit'($urandom_range(0, 1)),
           $urandom, ($urandom_range(0, 7) == 0), a);
      if (a) cur = rnd_cmd();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
